rv32i_boot_loader: RTL

//  Sits upstream of rv32i_soc memory. Receives a byte-stream program image and writes it

---
 rtl/rv32i_boot_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rv32i_boot_loader.sv
// Byte-stream program loader: receives a framed image, writes it word-by-word into memory
// and releases the core from reset only after the XOR checksum of the data bytes matches.
`timescale 1ns/1ps
module rv32i_boot_loader #(
  parameter int unsigned MEMORY_DEPTH   = 49152,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_wr_en,
  input  logic        i_wr_ready,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic [3:0]  o_wr_mask,
  output logic        o_core_rst,
  output logic        o_done,
  output logic        o_error
);

  localparam int unsigned MAX_WORDS = MEMORY_DEPTH / 4;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR
  } state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [7:0]  csum;
  logic [TW-1:0] idle_cnt;

  logic        xfer;
  logic        is_sync;
  logic        last_byte;
  logic        in_frame;
  logic        timeout;
  logic [31:0] len_next;

  assign xfer      = i_rx_valid && o_rx_ready;
  assign is_sync   = (i_rx_data == SYNC_BYTE);
  assign last_byte = (byte_cnt == 2'd3);
  assign in_frame  = (state == LEN) || (state == DATA) || (state == CSUM);
  assign timeout   = in_frame && !xfer && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign len_next  = {i_rx_data, word_cnt[31:8]};

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ERROR: begin
        if (xfer && is_sync) state_next = LEN;
      end
      LEN: begin
        if (timeout) begin
          state_next = ERROR;
        end else if (xfer && last_byte) begin
          if (len_next > 32'(MAX_WORDS)) state_next = ERROR;
          else if (len_next == '0)       state_next = CSUM;
          else                           state_next = DATA;
        end
      end
      DATA: begin
        if (timeout)                state_next = ERROR;
        else if (xfer && last_byte) state_next = WRITE;
      end
      WRITE: begin
        if (i_wr_ready) state_next = (word_cnt == 32'd1) ? CSUM : DATA;
      end
      CSUM: begin
        if (timeout)   state_next = ERROR;
        else if (xfer) state_next = (i_rx_data == csum) ? DONE : ERROR;
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_rx_ready = (state != WRITE) && (state != DONE);
    o_wr_en    = (state == WRITE);
    o_wr_mask  = (state == WRITE) ? 4'hF : 4'h0;
    o_core_rst = (state != DONE);
    o_done     = (state == DONE);
    o_error    = (state == ERROR);
  end

  // Length and data bytes arrive little-endian, so both are assembled by shifting in from the top.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_cnt  <= '0;
      word_cnt  <= '0;
      csum      <= '0;
      idle_cnt  <= '0;
      o_wr_addr <= BASE_ADDR;
      o_wr_data <= '0;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (xfer && is_sync) begin
            byte_cnt  <= '0;
            word_cnt  <= '0;
            csum      <= '0;
            idle_cnt  <= '0;
            o_wr_addr <= BASE_ADDR;
          end
        end
        LEN: begin
          if (xfer) begin
            word_cnt <= len_next;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        DATA: begin
          if (xfer) begin
            o_wr_data <= {i_rx_data, o_wr_data[31:8]};
            csum      <= csum ^ i_rx_data;
            byte_cnt  <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          if (i_wr_ready) begin
            o_wr_addr <= o_wr_addr + 32'd4;
            word_cnt  <= word_cnt - 32'd1;
          end
        end
        default: ;
      endcase

      // Idle counter only runs while waiting for frame bytes; it holds through WRITE.
      if (in_frame) begin
        if (xfer) idle_cnt <= '0;
        else      idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule
